// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and defaults for the data-memory port arbiter.
//   - arb_state_e : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   - arb_owner_e : which requester currently owns the RAM port
//   - DEF_ADDR_W / DEF_DATA_W : default port widths
//   - WAIT_W : width of the wait-state counter (WAIT_CYCLES is 0..15)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int WAIT_W     = 4;

endpackage

// File: rtl/dmem_arb_grant.sv
// -----------------------------------------------------------------------------
// dmem_arb_grant
//   Grant decision for the shared data-memory port. The CPU normally wins,
//   but a DMA requester that has been passed over STARVE_MAX times in a row
//   is forced through on the next arbitration.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset (clears starve counter)
//   cpu_req     in   CPU request level
//   dma_req     in   DMA/debug request level
//   sample_en   in   arbitration slot (arbiter is idle); counter only moves here
//   grant_valid out  a grant is issued this cycle
//   grant_dma   out  1 = DMA wins, 0 = CPU wins (meaningful with grant_valid)
// -----------------------------------------------------------------------------
module dmem_arb_grant #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic sample_en,
  output logic grant_valid,
  output logic grant_dma
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             starved;

  assign starved     = (starve_q == CNT_MAX);
  assign grant_valid = sample_en & (cpu_req | dma_req);
  assign grant_dma   = sample_en & dma_req & (starved | ~cpu_req);

  // Counts consecutive CPU wins over a waiting DMA. Any slot in which DMA is
  // not waiting, or in which DMA wins, ends the run.
  always_comb begin
    starve_d = starve_q;
    if (sample_en) begin
      if (grant_dma | ~dma_req) begin
        starve_d = '0;
      end else if (!starved) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares one data-memory port between the pipeline MEM stage (CPU) and a
//   DMA/debug requester. Each access is IDLE (grant) -> ACCESS (1+WAIT_CYCLES
//   cycles) -> RESP (one-cycle ack) -> IDLE, so a new request can be issued
//   every WAIT_CYCLES+3 cycles. Requests are sampled only in IDLE; the
//   winner's we/addr/wdata are latched at grant and later requester activity
//   cannot disturb the access in flight.
//
// Ports
//   clk, rst                  clock (rising) / asynchronous active-high reset
//   cpu_req/we/addr/wdata     CPU request, held until cpu_ack
//   cpu_ack                   one-cycle completion pulse
//   cpu_rdata                 read data, valid with cpu_ack and held after
//   cpu_stall                 cpu_req & ~cpu_ack, to the hazard unit
//   dma_req/we/addr/wdata     DMA request, same protocol as CPU
//   dma_ack, dma_rdata        DMA completion / read data
//   ram_re                    read strobe, high every ACCESS cycle of a read
//   ram_we                    write strobe, single pulse on last ACCESS cycle
//   ram_addr, ram_wdata       latched byte address / write data
//   ram_rdata                 combinational RAM read data
//   busy                      arbiter not idle
// -----------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,

  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,

  output logic              busy
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  arb_state_e        state_q,     state_d;
  arb_owner_e        owner_q,     owner_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [WAIT_W-1:0] wait_q,      wait_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic grant_valid;
  logic grant_dma;
  logic in_access;
  logic last_access;

  dmem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .sample_en   (state_q == IDLE),
    .grant_valid (grant_valid),
    .grant_dma   (grant_dma)
  );

  assign in_access   = (state_q == ACCESS);
  assign last_access = in_access & (wait_q == '0);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_dma ? OWN_DMA : OWN_CPU;
          we_d    = grant_dma ? dma_we    : cpu_we;
          addr_d  = grant_dma ? dma_addr  : cpu_addr;
          wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          wait_d  = WAIT_INIT;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (wait_q == '0) begin
          // RAM read data is combinational from ram_addr, so it is stable on
          // the final ACCESS cycle and captured at its closing edge.
          if (!we_q) begin
            if (owner_q == OWN_DMA) begin
              dma_rdata_d = ram_rdata;
            end else begin
              cpu_rdata_d = ram_rdata;
            end
          end
          state_d = RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Strobes decode from registered state only, so an asynchronous reset
  // drops ram_we immediately and a partially waited write never lands.
  assign ram_re    = in_access & ~we_q;
  assign ram_we    = last_access & we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign cpu_ack   = (state_q == RESP) & (owner_q == OWN_CPU);
  assign dma_ack   = (state_q == RESP) & (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wd, d_addr, d_wd;

  // instance A: WAIT_CYCLES=1, STARVE_MAX=4 ; instance B: WAIT_CYCLES=0, STARVE_MAX=2
  logic        a_cpu_ack, a_cpu_stall, a_dma_ack, a_ram_re, a_ram_we, a_busy;
  logic [31:0] a_cpu_rdata, a_dma_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic        b_cpu_ack, b_cpu_stall, b_dma_ack, b_ram_re, b_ram_we, b_busy;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;

  logic        sel;
  logic        o_cpu_ack, o_cpu_stall, o_dma_ack, o_ram_re, o_ram_we, o_busy;
  logic [31:0] o_cpu_rdata, o_dma_rdata, o_ram_addr, o_ram_wdata;

  logic [31:0] memA [0:255];
  logic [31:0] memB [0:255];
  logic        mem_init;

  // reference model state
  logic [31:0] exp_mem [0:255];
  logic [31:0] exp_cr, exp_dr;
  int          starve;
  int          cur_w, cur_smax;
  int          scr_mode;
  int          n_chk = 0;
  int          n_pass = 0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wd),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .dma_req(d_req), .dma_we(d_we), .dma_addr(d_addr), .dma_wdata(d_wd),
    .dma_ack(a_dma_ack), .dma_rdata(a_dma_rdata),
    .ram_re(a_ram_re), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .busy(a_busy)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .STARVE_MAX(2)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wd),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dma_req(d_req), .dma_we(d_we), .dma_addr(d_addr), .dma_wdata(d_wd),
    .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
    .ram_re(b_ram_re), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // word-indexed RAMs: combinational read, write on clock edge
  assign a_ram_rdata = memA[a_ram_addr[9:2]];
  assign b_ram_rdata = memB[b_ram_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) memA[i] <= 32'(i);
    end else if (a_ram_we) begin
      memA[a_ram_addr[9:2]] <= a_ram_wdata;
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) memB[i] <= 32'(i);
    end else if (b_ram_we) begin
      memB[b_ram_addr[9:2]] <= b_ram_wdata;
    end
  end

  assign o_cpu_ack   = sel ? b_cpu_ack   : a_cpu_ack;
  assign o_cpu_stall = sel ? b_cpu_stall : a_cpu_stall;
  assign o_dma_ack   = sel ? b_dma_ack   : a_dma_ack;
  assign o_ram_re    = sel ? b_ram_re    : a_ram_re;
  assign o_ram_we    = sel ? b_ram_we    : a_ram_we;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_cpu_rdata = sel ? b_cpu_rdata : a_cpu_rdata;
  assign o_dma_rdata = sel ? b_dma_rdata : a_dma_rdata;
  assign o_ram_addr  = sel ? b_ram_addr  : a_ram_addr;
  assign o_ram_wdata = sel ? b_ram_wdata : a_ram_wdata;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, act, exp);
  endtask

  task automatic exp_init();
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'(i);
  endtask

  task automatic model_reset();
    starve = 0;
    exp_cr = '0;
    exp_dr = '0;
  endtask

  task automatic new_req(input bit dma, input bit force_on);
    logic r;
    r = force_on || ($urandom_range(0, 3) != 0);
    if (dma) begin
      d_req = r; d_we = 1'($urandom_range(0, 1));
      d_addr = $urandom() & 32'hFFF0_003F; d_wd = $urandom();
    end else begin
      c_req = r; c_we = 1'($urandom_range(0, 1));
      c_addr = $urandom() & 32'hFFF0_003F; c_wd = $urandom();
    end
  endtask

  // One arbitration slot starting in an idle cycle with inputs already driven.
  // Expectations come from the grant rule and the fixed access timeline:
  // offset 0 grant, 1..W+1 access (write on W+1), W+2 ack.
  task automatic run_slot(output logic txn, output logic mdma, output logic seen_dma);
    logic        gd, we, acc, fin, resp;
    logic [31:0] a, wd;
    int          w;
    w = cur_w;
    txn = 1'b0; mdma = 1'b0; seen_dma = 1'b0;
    @(negedge clk);
    chk("idle_busy",  32'(o_busy),    32'd0);
    chk("idle_re",    32'(o_ram_re),  32'd0);
    chk("idle_we",    32'(o_ram_we),  32'd0);
    chk("idle_cack",  32'(o_cpu_ack), 32'd0);
    chk("idle_dack",  32'(o_dma_ack), 32'd0);
    chk("idle_stall", 32'(o_cpu_stall), 32'(c_req));
    if (!c_req && !d_req) begin
      starve = 0;
      @(posedge clk); #1;
      return;
    end
    gd = d_req && (starve == cur_smax || !c_req);
    if (gd || !d_req) starve = 0;
    else if (starve < cur_smax) starve++;
    we = gd ? d_we : c_we;
    a  = gd ? d_addr : c_addr;
    wd = gd ? d_wd : c_wd;
    txn = 1'b1; mdma = gd;
    for (int off = 1; off <= w + 2; off++) begin
      @(posedge clk); #1;
      if (off <= w + 1) begin
        if (scr_mode == 2 && !gd) begin
          c_addr = 32'h40;
        end else if (scr_mode == 1) begin
          if ($urandom_range(0, 1) == 1) begin
            if (gd) begin d_addr = $urandom(); d_wd = $urandom(); end
            else    begin c_addr = $urandom(); c_wd = $urandom(); end
          end
          if ($urandom_range(0, 3) == 0) begin
            if (gd) d_we = ~d_we; else c_we = ~c_we;
          end
          if ($urandom_range(0, 3) == 0) begin
            if (gd) d_req = 1'b0; else c_req = 1'b0;
          end
        end
      end
      @(negedge clk);
      acc  = (off <= w + 1);
      fin  = (off == w + 1);
      resp = (off == w + 2);
      chk("busy",   32'(o_busy),    32'd1);
      chk("ram_re", 32'(o_ram_re),  32'(acc & ~we));
      chk("ram_we", 32'(o_ram_we),  32'(fin & we));
      if (acc) chk("ram_addr", o_ram_addr, a);
      if (fin && we) chk("ram_wdata", o_ram_wdata, wd);
      chk("cpu_ack",   32'(o_cpu_ack),   32'(resp & ~gd));
      chk("dma_ack",   32'(o_dma_ack),   32'(resp & gd));
      chk("cpu_stall", 32'(o_cpu_stall), 32'(c_req & ~(resp & ~gd)));
      if (fin) begin
        if (!we) begin
          if (gd) exp_dr = exp_mem[a[9:2]];
          else    exp_cr = exp_mem[a[9:2]];
        end
      end
      if (resp) begin
        chk("cpu_rdata", o_cpu_rdata, exp_cr);
        chk("dma_rdata", o_dma_rdata, exp_dr);
        seen_dma = o_dma_ack;
      end
    end
    // the write lands on the edge closing the final access cycle
    if (we) exp_mem[a[9:2]] = wd;
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int n);
    logic txn, md, sd;
    for (int i = 0; i < n; i++) begin
      run_slot(txn, md, sd);
      if (txn) new_req(md, 1'b0);
      if (!c_req && $urandom_range(0, 1) == 1) new_req(1'b0, 1'b1);
      if (!d_req && $urandom_range(0, 1) == 1) new_req(1'b1, 1'b1);
    end
  endtask

  initial begin
    logic       txn, md, sd;
    logic [9:0] order;
    sel = 1'b0; cur_w = 1; cur_smax = 4; scr_mode = 0;
    rst = 1'b1; mem_init = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wd = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;
    exp_init();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(o_busy),     32'd0);
    chk("rst_cack",   32'(o_cpu_ack),  32'd0);
    chk("rst_dack",   32'(o_dma_ack),  32'd0);
    chk("rst_re",     32'(o_ram_re),   32'd0);
    chk("rst_we",     32'(o_ram_we),   32'd0);
    chk("rst_addr",   o_ram_addr,      32'd0);
    chk("rst_wdata",  o_ram_wdata,     32'd0);
    chk("rst_crdata", o_cpu_rdata,     32'd0);
    chk("rst_drdata", o_dma_rdata,     32'd0);
    chk("rst_stall",  32'(o_cpu_stall), 32'd0);
    rst = 1'b0; mem_init = 1'b0;
    @(posedge clk); #1;

    // CPU read of 0x10 (RAM word 4 holds 0x4)
    c_req = 1; c_we = 0; c_addr = 32'h10;
    run_slot(txn, md, sd);
    c_req = 0;
    chk("t1_rdata", o_cpu_rdata, 32'h4);

    // CPU write 0xDEAD to 0x8, then read it back
    c_req = 1; c_we = 1; c_addr = 32'h8; c_wd = 32'hDEAD;
    run_slot(txn, md, sd);
    c_req = 0;
    chk("t2_mem", memA[2], 32'hDEAD);
    c_req = 1; c_we = 0; c_addr = 32'h8;
    run_slot(txn, md, sd);
    c_req = 0;
    chk("t2_readback", o_cpu_rdata, 32'hDEAD);
    run_slot(txn, md, sd);

    // both held: CPU x4, DMA, CPU x4, DMA
    order = 10'b10_0001_0000;
    c_req = 1; c_we = 0; c_addr = 32'h4;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      run_slot(txn, md, sd);
      chk("t3_order", 32'(sd), 32'(order[i]));
      new_req(md, 1'b1);
    end
    c_req = 0; d_req = 0;
    run_slot(txn, md, sd);

    // requester address changes during the access
    c_req = 1; c_we = 0; c_addr = 32'h4; scr_mode = 2;
    run_slot(txn, md, sd);
    scr_mode = 0; c_req = 0;

    // reset in the first access cycle of a write
    c_req = 1; c_we = 1; c_addr = 32'h30; c_wd = 32'hBEEF;
    @(negedge clk);
    chk("t5_busy0", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk("t5_busy1", 32'(o_busy), 32'd1);
    rst = 1'b1; #1;
    chk("t5_we",   32'(o_ram_we),  32'd0);
    chk("t5_busy", 32'(o_busy),    32'd0);
    chk("t5_cack", 32'(o_cpu_ack), 32'd0);
    chk("t5_addr", o_ram_addr,     32'd0);
    c_req = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("t5_mem", memA[12], exp_mem[12]);
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 32'h30;
    run_slot(txn, md, sd);
    c_req = 0;
    chk("t5_rd", o_cpu_rdata, 32'hC);

    // randomized traffic on instance A
    scr_mode = 1;
    rand_run(300);
    scr_mode = 0;

    // switch to instance B (no wait states, STARVE_MAX=2)
    c_req = 0; d_req = 0;
    @(negedge clk);
    rst = 1'b1; mem_init = 1'b1; sel = 1'b1; cur_w = 0; cur_smax = 2;
    exp_init();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0; mem_init = 1'b0;
    @(posedge clk); #1;

    // DMA-only read of 0x20 (word 8)
    d_req = 1; d_we = 0; d_addr = 32'h20;
    run_slot(txn, md, sd);
    d_req = 0;
    chk("t4_drdata", o_dma_rdata, 32'h8);
    chk("t4_crdata", o_cpu_rdata, 32'h0);
    chk("t4_owner",  32'(sd),     32'd1);

    scr_mode = 1;
    rand_run(200);
    scr_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
